// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the memory stage: funct3 codes, LSU FSM states, store strobes.
package riscv_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT_R = 2'd2,
        ST_DONE   = 2'd3
    } lsu_state_t;

    localparam logic [3:0] STRB_B = 4'b0001;
    localparam logic [3:0] STRB_H = 4'b0011;
    localparam logic [3:0] STRB_W = 4'b1111;

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/halfword out of a memory word and sign- or zero-extends it.
module load_align
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic [1:0]            addr_lo,
    input  logic [2:0]            funct3,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] b_shift;
    logic [DATA_WIDTH-1:0] h_shift;
    logic [7:0]            b_sel;
    logic [15:0]           h_sel;

    always_comb begin
        b_shift = mem_rdata >> {addr_lo, 3'b000};
        h_shift = mem_rdata >> {addr_lo[1], 4'b0000};
        b_sel   = b_shift[7:0];
        h_sel   = h_shift[15:0];
        case (funct3)
            F3_LB:   rdata = {{(DATA_WIDTH-8){b_sel[7]}}, b_sel};
            F3_LBU:  rdata = {{(DATA_WIDTH-8){1'b0}}, b_sel};
            F3_LH:   rdata = {{(DATA_WIDTH-16){h_sel[15]}}, h_sel};
            F3_LHU:  rdata = {{(DATA_WIDTH-16){1'b0}}, h_sel};
            default: rdata = mem_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: request/grant/response memory port, store lane shifting, load extension.
// Define MISALIGN_TRAP_EN to flag misaligned accesses; otherwise addresses are forced to natural alignment.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic                  lsu_load,
    input  logic [2:0]            lsu_funct3,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic [DATA_WIDTH-1:0] lsu_wdata,
    input  logic [4:0]            lsu_rd,
    output logic                  lsu_stall,
    output logic                  lsu_done,
    output logic                  lsu_wb_en,
    output logic [DATA_WIDTH-1:0] lsu_rdata,
    output logic [4:0]            lsu_rd_out,
    output logic                  lsu_error,
    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_wstrb,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output lsu_state_t            dbg_state
);

    lsu_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            funct3_q, funct3_d;
    logic                  load_q, load_d;
    logic [4:0]            rd_q, rd_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [4:0]            rd_out_q, rd_out_d;

    logic [1:0]            size;
    logic                  f3_illegal;
    logic                  misaligned;
    logic [ADDR_WIDTH-1:0] addr_eff;
    logic [3:0]            strb_new;
    logic [DATA_WIDTH-1:0] wdata_new;
    logic [DATA_WIDTH-1:0] load_ext;

    // Decode of the operation presented at the input; only used in the acceptance cycle.
    always_comb begin
        size       = lsu_funct3[1:0];
        f3_illegal = lsu_load ? (lsu_funct3 == 3'b011 || lsu_funct3[2:1] == 2'b11)
                              : (lsu_funct3 > F3_SW);
        addr_eff   = lsu_addr;
`ifdef MISALIGN_TRAP_EN
        misaligned = (size == 2'b01 && lsu_addr[0]) ||
                     (size == 2'b10 && lsu_addr[1:0] != 2'b00);
`else
        misaligned = 1'b0;
        if (size == 2'b01) addr_eff[0] = 1'b0;
        if (size == 2'b10) addr_eff[1:0] = 2'b00;
`endif
        case (size)
            2'b00: begin
                strb_new  = STRB_B << addr_eff[1:0];
                wdata_new = {(DATA_WIDTH/8){lsu_wdata[7:0]}};
            end
            2'b01: begin
                strb_new  = STRB_H << {addr_eff[1], 1'b0};
                wdata_new = {(DATA_WIDTH/16){lsu_wdata[15:0]}};
            end
            default: begin
                strb_new  = STRB_W;
                wdata_new = lsu_wdata;
            end
        endcase
    end

    load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
        .mem_rdata (mem_rdata),
        .addr_lo   (addr_q[1:0]),
        .funct3    (funct3_q),
        .rdata     (load_ext)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        load_d   = load_q;
        rd_d     = rd_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        rd_out_d = rd_out_q;
        case (state_q)
            ST_IDLE: begin
                if (lsu_valid) begin
                    addr_d   = addr_eff;
                    funct3_d = lsu_funct3;
                    load_d   = lsu_load;
                    rd_d     = lsu_rd;
                    wdata_d  = wdata_new;
                    wstrb_d  = lsu_load ? 4'b0000 : strb_new;
                    err_d    = f3_illegal || misaligned;
                    state_d  = (f3_illegal || misaligned) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_gnt) state_d = load_q ? ST_WAIT_R : ST_DONE;
            end
            ST_WAIT_R: begin
                if (mem_rvalid) begin
                    rdata_d  = load_ext;
                    rd_out_d = rd_q;
                    state_d  = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            funct3_q <= '0;
            load_q   <= 1'b0;
            rd_q     <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            rd_out_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            load_q   <= load_d;
            rd_q     <= rd_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            rd_out_q <= rd_out_d;
        end
    end

    // Request signals decode straight from state so reset drops them without waiting for a clock.
    assign lsu_ready  = (state_q == ST_IDLE);
    assign lsu_stall  = (state_q != ST_IDLE) || lsu_valid;
    assign lsu_done   = (state_q == ST_DONE);
    assign lsu_wb_en  = (state_q == ST_DONE) && load_q && !err_q;
    assign lsu_error  = (state_q == ST_DONE) && err_q;
    assign lsu_rdata  = rdata_q;
    assign lsu_rd_out = rd_out_q;
    assign mem_req    = (state_q == ST_REQ);
    assign mem_we     = (state_q == ST_REQ) && !load_q;
    assign mem_addr   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign mem_wstrb  = wstrb_q;
    assign mem_wdata  = wdata_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized loads/stores against a byte-level model.
module tb_load_store_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic        lsu_load = 1'b0;
  logic [2:0]  lsu_funct3 = '0;
  logic [31:0] lsu_addr = '0;
  logic [31:0] lsu_wdata = '0;
  logic [4:0]  lsu_rd = '0;
  logic        lsu_stall;
  logic        lsu_done;
  logic        lsu_wb_en;
  logic [31:0] lsu_rdata;
  logic [4:0]  lsu_rd_out;
  logic        lsu_error;
  logic        mem_req;
  logic        mem_gnt = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  lsu_state_t  dbg_state;

  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rdata = '0;
  logic [4:0]  last_rd = '0;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_load(lsu_load),
    .lsu_funct3(lsu_funct3), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_rd(lsu_rd), .lsu_stall(lsu_stall), .lsu_done(lsu_done),
    .lsu_wb_en(lsu_wb_en), .lsu_rdata(lsu_rdata), .lsu_rd_out(lsu_rd_out),
    .lsu_error(lsu_error), .mem_req(mem_req), .mem_gnt(mem_gnt),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  // reference model
  function automatic int m_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00: return 1;
      2'b01: return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit m_illegal(input bit ld, input logic [2:0] f3);
    if (ld) return !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    return f3 > 3'd2;
  endfunction

  function automatic bit m_err(input bit ld, input logic [2:0] f3, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
    return m_illegal(ld, f3) || ((a % m_size(f3)) != 0);
`else
    return m_illegal(ld, f3);
`endif
  endfunction

  function automatic logic [31:0] m_eff(input logic [2:0] f3, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
    return a;
`else
    return a - (a % m_size(f3));
`endif
  endfunction

  function automatic logic [31:0] m_mask(input int sz);
    if (sz == 4) return 32'hFFFF_FFFF;
    return (32'd1 << (8 * sz)) - 32'd1;
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
    int sz;
    logic [3:0] lanes;
    sz = m_size(f3);
    lanes = 4'((1 << sz) - 1);
    return 4'(lanes << (m_eff(f3, a) % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int sz;
    logic [31:0] v;
    sz = m_size(f3);
    v = 0;
    for (int i = 0; i < 4 / sz; i++) v = v | ((wd & m_mask(sz)) << (8 * sz * i));
    return v;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word);
    int sz;
    logic [31:0] v, msk;
    sz = m_size(f3);
    msk = m_mask(sz);
    v = (word >> (8 * (m_eff(f3, a) % 4))) & msk;
    if (f3 < 3'd4 && sz < 4 && v[8 * sz - 1]) v = v | ~msk;
    return v;
  endfunction

  // driver: presents one operation and plays the memory side with the given delays
  task automatic run_op(input bit ld, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] rd,
                        input int gd, input int rvd, input logic [31:0] word);
    bit err;
    logic [31:0] eff;
    err = m_err(ld, f3, addr);
    eff = m_eff(f3, addr);
    @(negedge clk);
    check("ready_idle", lsu_ready, 1);
    lsu_valid = 1'b1; lsu_load = ld; lsu_funct3 = f3;
    lsu_addr = addr; lsu_wdata = wd; lsu_rd = rd;
    #1;
    check("stall_accept", lsu_stall, 1);
    if (ld && !err) exp_q.push_back(m_load(f3, addr, word));
    @(posedge clk);
    #1;
    lsu_valid = 1'b0; lsu_wdata = $urandom; lsu_addr = $urandom;
    @(negedge clk);
    if (err) begin
      check("err_no_req", mem_req, 0);
      check("err_done", lsu_done, 1);
      check("err_flag", lsu_error, 1);
      check("err_wb_en", lsu_wb_en, 0);
      check("err_rdata_hold", lsu_rdata, last_rdata);
    end else begin
      for (int k = 0; k <= gd; k++) begin
        check("req", mem_req, 1);
        check("req_stall", lsu_stall, 1);
        check("req_addr", mem_addr, eff & 32'hFFFF_FFFC);
        check("req_we", mem_we, !ld);
        if (!ld) begin
          check("req_wstrb", mem_wstrb, m_strb(f3, addr));
          check("req_wdata", mem_wdata, m_wdata(f3, wd));
        end
        check("req_no_done", lsu_done, 0);
        if (k == gd) mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
      end
      if (ld) begin
        for (int k = 0; k <= rvd; k++) begin
          check("wait_r_idle_port", {mem_req, lsu_done}, 0);
          if (k == rvd) begin
            mem_rvalid = 1'b1;
            mem_rdata = word;
          end
          @(negedge clk);
          mem_rvalid = 1'b0;
          mem_rdata = $urandom;
        end
        if (exp_q.size() > 0) last_rdata = exp_q.pop_front();
        last_rd = rd;
      end
      check("done", lsu_done, 1);
      check("done_stall", lsu_stall, 1);
      check("done_no_req", mem_req, 0);
      check("done_error", lsu_error, 0);
      check("done_wb_en", lsu_wb_en, ld);
      check("rdata", lsu_rdata, last_rdata);
      check("rd_out", lsu_rd_out, last_rd);
    end
    check("done_not_ready", lsu_ready, 0);
    @(negedge clk);
    check("done_pulse", lsu_done, 0);
  endtask

  initial begin
    logic [2:0] f3;
    logic [31:0] a;
    bit ld;

    // reset state
    #12;
    check("rst_ready", lsu_ready, 1);
    check("rst_stall", lsu_stall, 0);
    check("rst_req", mem_req, 0);
    check("rst_done", {lsu_done, lsu_wb_en, lsu_error}, 0);
    check("rst_rdata", lsu_rdata, 0);
    check("rst_wstrb", mem_wstrb, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed cases
    run_op(1, F3_LB,  32'h1003, 0, 5'd3, 0, 0, 32'h80FF_FF00);
    check("lb_value", lsu_rdata, 32'hFFFF_FF80);
    run_op(1, F3_LHU, 32'h2002, 0, 5'd7, 1, 2, 32'h8001_1234);
    check("lhu_value", lsu_rdata, 32'h0000_8001);
    run_op(0, F3_SB,  32'h3001, 32'h0000_00AB, 5'd9, 3, 0, 0);
    run_op(1, F3_LW,  32'h4002, 0, 5'd11, 0, 1, 32'hDEAD_BEEF);
    run_op(1, 3'b011, 32'h5000, 0, 5'd12, 0, 0, 0);
    run_op(0, 3'b100, 32'h5004, 32'h1234_5678, 5'd1, 0, 0, 0);
    run_op(0, F3_SH,  32'h6002, 32'hFFFF_C3A5, 5'd1, 0, 0, 0);

    // spurious read data while idle
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("spurious_rvalid_done", lsu_done, 0);
      check("spurious_rvalid_rdata", lsu_rdata, last_rdata);
    end
    mem_rvalid = 1'b0;

    // reset while waiting for read data
    @(negedge clk);
    lsu_valid = 1'b1; lsu_load = 1'b1; lsu_funct3 = F3_LW; lsu_addr = 32'h80; lsu_rd = 5'd4;
    @(negedge clk);
    lsu_valid = 1'b0;
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check("wait_r_stall", lsu_stall, 1);
    rst_n = 1'b0;
    #1;
    check("rst_async_req", mem_req, 0);
    check("rst_async_stall", lsu_stall, 0);
    check("rst_async_ready", lsu_ready, 1);
    last_rdata = '0;
    last_rd = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, F3_SW, 32'h10, 32'hCAFE_F00D, 5'd2, 0, 0, 0);

    // randomized operations
    for (int n = 0; n < 60; n++) begin
      ld = 1'($urandom_range(0, 1));
      f3 = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7))
           : (ld ? 3'($urandom_range(0, 5)) : 3'($urandom_range(0, 2)));
      a = $urandom;
      run_op(ld, f3, a, $urandom, 5'($urandom_range(0, 31)),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    check("exp_q_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
